// File: rtl/mem_stage_hs_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
// The request side is valid/ready; the response side is a one-cycle valid pulse.
interface mem_stage_hs_if #(
  parameter int XLEN = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [XLEN-1:0]   dmem_req_addr;
  logic [XLEN/8-1:0] dmem_req_be;
  logic [XLEN-1:0]   dmem_req_wdata;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM/WB stage with a stallable valid/ready data-memory port: lane alignment, load
// extension, misalignment trapping, flush, and a registered valid-qualified WB bundle.
module mem_stage_hs #(
  parameter int XLEN      = 32,
  parameter int CTRL_WB_W = 3,
  parameter int RD_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic [2:0]           in_funct3,
  input  logic [CTRL_WB_W-1:0] in_ctrl_wb,
  input  logic [RD_W-1:0]      in_rd,
  input  logic [XLEN-1:0]      in_pc4,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_store_data,
  mem_stage_hs_if.master       dmem,
  output logic                 wb_valid,
  output logic [CTRL_WB_W-1:0] wb_ctrl,
  output logic [RD_W-1:0]      wb_rd,
  output logic [XLEN-1:0]      wb_pc4,
  output logic [XLEN-1:0]      wb_mem_data,
  output logic [XLEN-1:0]      wb_alu_data,
  output logic                 wb_misaligned
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t               r_state;
  logic                 r_drop;
  logic                 r_req_valid;
  logic                 r_req_we;
  logic [XLEN-1:0]      r_req_addr;
  logic [NB-1:0]        r_req_be;
  logic [XLEN-1:0]      r_req_wdata;
  logic [CTRL_WB_W-1:0] r_op_ctrl;
  logic [RD_W-1:0]      r_op_rd;
  logic [XLEN-1:0]      r_op_pc4;
  logic [XLEN-1:0]      r_op_alu;
  logic [2:0]           r_op_funct3;
  logic                 r_wb_valid;
  logic [CTRL_WB_W-1:0] r_wb_ctrl;
  logic [RD_W-1:0]      r_wb_rd;
  logic [XLEN-1:0]      r_wb_pc4;
  logic [XLEN-1:0]      r_wb_mem_data;
  logic [XLEN-1:0]      r_wb_alu_data;
  logic                 r_wb_misaligned;

  logic                 w_accept;
  logic                 w_is_mem;
  logic                 w_misaligned;
  logic                 w_handshake;
  logic [LW-1:0]        w_lane;
  logic [NB-1:0]        w_size_mask;
  logic [NB-1:0]        w_be;
  logic [XLEN-1:0]      w_wdata;
  logic [XLEN-1:0]      w_addr;

  // Move the addressed lane to bit 0, then sign/zero-extend from the access size.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                  input logic [LW-1:0]   lane,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] shifted;
    int              top;
    shifted = word >> {lane, 3'b000};
    top     = XLEN - (8 << f3[1:0]);
    if (top < 0) top = 0;
    shifted = shifted << top;
    if (f3[2]) return shifted >> top;
    return XLEN'($signed(shifted) >>> top);
  endfunction

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_is_mem    = in_mem_read || in_mem_write;
  assign w_handshake = r_req_valid && dmem.dmem_req_ready;
  assign w_lane      = in_alu_result[LW-1:0];
  assign w_addr      = {in_alu_result[XLEN-1:LW], {LW{1'b0}}};
  assign w_be        = w_size_mask << w_lane;
  assign w_wdata     = in_store_data << {w_lane, 3'b000};

  // Doubleword accesses have no lane mapping on a 32-bit datapath and trap as misaligned.
  assign w_misaligned = ((in_funct3[1:0] == 2'd1) && in_alu_result[0]) ||
                        ((in_funct3[1:0] == 2'd2) && (in_alu_result[1:0] != 2'd0)) ||
                        ((in_funct3[1:0] == 2'd3) && ((XLEN == 32) || (in_alu_result[2:0] != 3'd0)));

  always_comb begin
    w_size_mask = '0;
    case (in_funct3[1:0])
      2'd0:    w_size_mask = NB'(8'h01);
      2'd1:    w_size_mask = NB'(8'h03);
      2'd2:    w_size_mask = NB'(8'h0F);
      default: w_size_mask = NB'(8'hFF);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_drop          <= 1'b0;
      r_req_valid     <= 1'b0;
      r_req_we        <= 1'b0;
      r_req_addr      <= '0;
      r_req_be        <= '0;
      r_req_wdata     <= '0;
      r_op_ctrl       <= '0;
      r_op_rd         <= '0;
      r_op_pc4        <= '0;
      r_op_alu        <= '0;
      r_op_funct3     <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_ctrl       <= '0;
      r_wb_rd         <= '0;
      r_wb_pc4        <= '0;
      r_wb_mem_data   <= '0;
      r_wb_alu_data   <= '0;
      r_wb_misaligned <= 1'b0;
    end else begin
      r_wb_valid      <= 1'b0;
      r_wb_ctrl       <= '0;
      r_wb_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_ctrl   <= in_ctrl_wb;
            r_op_rd     <= in_rd;
            r_op_pc4    <= in_pc4;
            r_op_alu    <= in_alu_result;
            r_op_funct3 <= in_funct3;
            if (w_is_mem && !w_misaligned) begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
              r_req_we    <= in_mem_write;
              r_req_addr  <= w_addr;
              r_req_be    <= w_be;
              r_req_wdata <= w_wdata;
            end else begin
              // In this branch a memory op is necessarily a misaligned one.
              r_wb_valid      <= 1'b1;
              r_wb_ctrl       <= w_is_mem ? '0 : in_ctrl_wb;
              r_wb_misaligned <= w_is_mem;
              r_wb_rd         <= in_rd;
              r_wb_pc4        <= in_pc4;
              r_wb_alu_data   <= in_alu_result;
            end
          end
        end
        S_REQ: begin
          if (w_handshake) begin
            r_req_valid <= 1'b0;
            if (r_req_we) begin
              r_state <= S_IDLE;
              if (!flush) begin
                r_wb_valid    <= 1'b1;
                r_wb_ctrl     <= r_op_ctrl;
                r_wb_rd       <= r_op_rd;
                r_wb_pc4      <= r_op_pc4;
                r_wb_alu_data <= r_op_alu;
              end
            end else begin
              r_state <= S_RSP;
              r_drop  <= flush;
            end
          end else if (flush) begin
            r_req_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_RSP: begin
          if (dmem.dmem_rsp_valid) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            if (!r_drop && !flush) begin
              r_wb_valid    <= 1'b1;
              r_wb_ctrl     <= r_op_ctrl;
              r_wb_rd       <= r_op_rd;
              r_wb_pc4      <= r_op_pc4;
              r_wb_alu_data <= r_op_alu;
              r_wb_mem_data <= extend_load(dmem.dmem_rsp_rdata, r_op_alu[LW-1:0], r_op_funct3);
            end
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_valid = r_req_valid;
  assign dmem.dmem_req_we    = r_req_we;
  assign dmem.dmem_req_addr  = r_req_addr;
  assign dmem.dmem_req_be    = r_req_be;
  assign dmem.dmem_req_wdata = r_req_wdata;

  assign wb_valid      = r_wb_valid;
  assign wb_ctrl       = r_wb_ctrl;
  assign wb_rd         = r_wb_rd;
  assign wb_pc4        = r_wb_pc4;
  assign wb_mem_data   = r_wb_mem_data;
  assign wb_alu_data   = r_wb_alu_data;
  assign wb_misaligned = r_wb_misaligned;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed latency/flush/reset scenarios plus a randomized op
// stream checked against a byte-level transaction model and a randomly stalling memory.
module tb_mem_stage_hs;
  localparam int XLEN = 32;
  localparam int CW   = 3;
  localparam int RW   = 5;
  localparam int NB   = XLEN / 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_mem_read = 1'b0;
  logic            in_mem_write = 1'b0;
  logic [2:0]      in_funct3 = '0;
  logic [CW-1:0]   in_ctrl_wb = '0;
  logic [RW-1:0]   in_rd = '0;
  logic [XLEN-1:0] in_pc4 = '0;
  logic [XLEN-1:0] in_alu_result = '0;
  logic [XLEN-1:0] in_store_data = '0;
  logic            wb_valid;
  logic [CW-1:0]   wb_ctrl;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_pc4;
  logic [XLEN-1:0] wb_mem_data;
  logic [XLEN-1:0] wb_alu_data;
  logic            wb_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.XLEN(XLEN)) dmem ();

  mem_stage_hs #(.XLEN(XLEN), .CTRL_WB_W(CW), .RD_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_ctrl_wb(in_ctrl_wb), .in_rd(in_rd), .in_pc4(in_pc4),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .dmem(dmem),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .wb_pc4(wb_pc4),
    .wb_mem_data(wb_mem_data), .wb_alu_data(wb_alu_data), .wb_misaligned(wb_misaligned)
  );

  // ---------------- memory responder (acts on the falling edge) ----------------
  typedef struct {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
  } hs_t;

  hs_t             hs_q[$];
  int              mem_mode = 1;      // 0 random ready, 1 always ready, 2 never ready
  int              mem_delay_min = 0;
  int              mem_delay_max = 0;
  bit              force_rdata_en = 1'b0;
  logic [XLEN-1:0] force_rdata = '0;

  initial begin
    hs_t             h;
    bit              rsp_pending;
    int              rsp_delay;
    logic [XLEN-1:0] rsp_data;
    rsp_pending = 1'b0;
    rsp_delay   = 0;
    rsp_data    = '0;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      dmem.dmem_rsp_valid = 1'b0;
      if (rsp_pending) begin
        if (rsp_delay == 0) begin
          dmem.dmem_rsp_valid = 1'b1;
          dmem.dmem_rsp_rdata = rsp_data;
          rsp_pending = 1'b0;
        end else begin
          rsp_delay--;
        end
      end
      case (mem_mode)
        0:       dmem.dmem_req_ready = ($urandom_range(0, 9) < 7);
        1:       dmem.dmem_req_ready = 1'b1;
        default: dmem.dmem_req_ready = 1'b0;
      endcase
      if (dmem.dmem_req_valid && dmem.dmem_req_ready) begin
        h.we    = dmem.dmem_req_we;
        h.addr  = dmem.dmem_req_addr;
        h.be    = dmem.dmem_req_be;
        h.wdata = dmem.dmem_req_wdata;
        h.rdata = '0;
        if (!dmem.dmem_req_we) begin
          rsp_data    = force_rdata_en ? force_rdata : XLEN'($urandom);
          rsp_pending = 1'b1;
          rsp_delay   = $urandom_range(mem_delay_min, mem_delay_max);
          h.rdata     = rsp_data;
        end
        hs_q.push_back(h);
      end
    end
  end

  // ---------------- reference model (byte-level view of a memory access) ----------------
  function automatic bit m_misaligned(input logic [XLEN-1:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return (XLEN == 32) || (a % 8 != 0);
    return (a % (1 << sz)) != 0;
  endfunction

  function automatic logic [NB-1:0] m_be(input logic [XLEN-1:0] a, input logic [1:0] sz);
    logic [NB-1:0] r;
    int lane;
    r = '0;
    lane = int'(a % NB);
    for (int b = 0; b < NB; b++) r[b] = (b >= lane) && (b < lane + (1 << sz));
    return r;
  endfunction

  function automatic logic [XLEN-1:0] m_wdata(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    int lane;
    r = '0;
    lane = int'(a % NB);
    for (int b = 0; b < NB; b++) if (b >= lane) r[8*b +: 8] = d[8*(b-lane) +: 8];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] m_load(input logic [XLEN-1:0] word, input logic [XLEN-1:0] a,
                                             input logic [2:0] f3);
    logic [63:0] v;
    int lane, n;
    v = '0;
    lane = int'(a % NB);
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(lane+i) +: 8];
    if (!f3[2] && v[8*n-1] && n < 8) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
    return v[XLEN-1:0];
  endfunction

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [CW-1:0] ctrl, input logic [RW-1:0] rd,
                        input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] sd);
    in_valid      = 1'b1;
    in_mem_read   = rd_en;
    in_mem_write  = wr_en;
    in_funct3     = f3;
    in_ctrl_wb    = ctrl;
    in_rd         = rd;
    in_pc4        = pc4;
    in_alu_result = alu;
    in_store_data = sd;
  endtask

  task automatic pop_hs(input string tag, output hs_t h);
    check_eq({tag, "_hs_count"}, 64'(hs_q.size()), 64'd1);
    h = '{we: 1'b0, addr: '0, be: '0, wdata: '0, rdata: '0};
    if (hs_q.size() > 0) h = hs_q.pop_front();
    hs_q.delete();
  endtask

  // Send the op already set on the inputs; count cycles from acceptance to wb_valid.
  task automatic run_lat(input string tag, input int exp_lat);
    int c;
    tick();
    in_valid = 1'b0;
    c = 1;
    while (!wb_valid && c < 30) begin
      tick();
      c++;
    end
    check_eq({tag, "_latency"}, 64'(c), 64'(exp_lat));
  endtask

  // Randomized op through the model; memory ops offer a decoy op while the stage is busy.
  task automatic run_op(input int idx, input int kind, input logic [2:0] f3,
                        input logic [CW-1:0] ctrl, input logic [RW-1:0] rd,
                        input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] sd);
    bit  is_mem, mis;
    int  c;
    hs_t h;
    is_mem = (kind != 0);
    mis    = is_mem && m_misaligned(alu, f3[1:0]);
    set_op(kind == 1, kind == 2, f3, ctrl, rd, pc4, alu, sd);
    tick();
    in_valid = 1'b0;
    if (!is_mem || mis) begin
      check_eq("imm_wb_valid", wb_valid, 1'b1);
      check_eq("imm_wb_ctrl", wb_ctrl, mis ? '0 : ctrl);
      check_eq("imm_wb_mis", wb_misaligned, mis);
      check_eq("imm_no_req", dmem.dmem_req_valid, 1'b0);
      check_eq("imm_hs_none", 64'(hs_q.size()), 64'd0);
    end else begin
      c = 0;
      while (!wb_valid && c < 60) begin
        check_eq("busy_in_ready", in_ready, 1'b0);
        check_eq("idle_wb_ctrl", wb_ctrl, '0);
        set_op(1'b0, 1'b0, 3'd0, 3'd7, 5'd31, XLEN'($urandom), XLEN'($urandom), '0);
        tick();
        c++;
      end
      in_valid = 1'b0;
      check_eq("retire_seen", wb_valid, 1'b1);
      check_eq("retire_in_ready", in_ready, 1'b1);
      check_eq("mem_wb_ctrl", wb_ctrl, ctrl);
      check_eq("mem_wb_mis", wb_misaligned, 1'b0);
      pop_hs("mem", h);
      check_eq("req_we", h.we, kind == 2);
      check_eq("req_addr", h.addr, alu - (alu % NB));
      check_eq("req_be", h.be, m_be(alu, f3[1:0]));
      if (kind == 2) check_eq("req_wdata", h.wdata, m_wdata(alu, sd));
      else check_eq("load_data", wb_mem_data, m_load(h.rdata, alu, f3));
    end
    check_eq("wb_rd", wb_rd, rd);
    check_eq("wb_pc4", wb_pc4, pc4);
    check_eq("wb_alu", wb_alu_data, alu);
    $display("txn %0d kind=%0d f3=%0d addr=0x%08h mis=%0d", idx, kind, f3, alu, mis);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    hs_t h;
    int  pulses;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_wb_ctrl", wb_ctrl, '0);
    check_eq("rst_req_valid", dmem.dmem_req_valid, 1'b0);
    check_eq("rst_req_addr", dmem.dmem_req_addr, '0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    tick();

    // LB / LBU at a lane-3 byte with zero-wait memory.
    mem_mode = 1; mem_delay_min = 0; mem_delay_max = 0;
    force_rdata_en = 1'b1; force_rdata = 32'h80FF_1234;
    set_op(1'b1, 1'b0, 3'b000, 3'b101, 5'd7, 32'h104, 32'h1003, 32'h0);
    run_lat("lb", 3);
    check_eq("lb_data", wb_mem_data, 32'hFFFF_FF80);
    check_eq("lb_ctrl", wb_ctrl, 3'b101);
    check_eq("lb_rd", wb_rd, 5'd7);
    pop_hs("lb", h);
    check_eq("lb_be", h.be, 4'h8);
    check_eq("lb_addr", h.addr, 32'h1000);
    set_op(1'b1, 1'b0, 3'b100, 3'b011, 5'd8, 32'h108, 32'h1003, 32'h0);
    run_lat("lbu", 3);
    check_eq("lbu_data", wb_mem_data, 32'h0000_0080);
    pop_hs("lbu", h);
    force_rdata_en = 1'b0;

    // SH to lane 2.
    set_op(1'b0, 1'b1, 3'b001, 3'b110, 5'd9, 32'h10C, 32'h2002, 32'h0000_ABCD);
    run_lat("sh", 2);
    check_eq("sh_ctrl", wb_ctrl, 3'b110);
    pop_hs("sh", h);
    check_eq("sh_be", h.be, 4'hC);
    check_eq("sh_wdata", h.wdata, 32'hABCD_0000);
    check_eq("sh_we", h.we, 1'b1);

    // LW with the memory refusing for four cycles.
    mem_mode = 2;
    set_op(1'b1, 1'b0, 3'b010, 3'b001, 5'd10, 32'h110, 32'h3000, 32'h0);
    tick();
    set_op(1'b0, 1'b0, 3'd0, 3'd2, 5'd1, 32'h0, 32'hDEAD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_req_valid", dmem.dmem_req_valid, 1'b1);
      check_eq("stall_req_addr", dmem.dmem_req_addr, 32'h3000);
      check_eq("stall_req_be", dmem.dmem_req_be, 4'hF);
      check_eq("stall_req_we", dmem.dmem_req_we, 1'b0);
      check_eq("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    mem_mode = 1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      pulses += int'(wb_valid);
      tick();
    end
    check_eq("stall_wb_pulses", 64'(pulses), 64'd1);
    pop_hs("stall", h);

    // Misaligned LW then three back-to-back ALU ops.
    set_op(1'b1, 1'b0, 3'b010, 3'b111, 5'd11, 32'h114, 32'h1002, 32'h0);
    run_lat("mis", 1);
    check_eq("mis_flag", wb_misaligned, 1'b1);
    check_eq("mis_ctrl", wb_ctrl, '0);
    check_eq("mis_no_req", dmem.dmem_req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_op(1'b0, 1'b0, 3'd0, 3'd4, RW'(i + 1), XLEN'(32'h200 + 4 * i), XLEN'(32'h5000 + i), 32'h0);
      tick();
      check_eq("b2b_valid", wb_valid, 1'b1);
      check_eq("b2b_alu", wb_alu_data, XLEN'(32'h5000 + i));
    end
    in_valid = 1'b0;
    tick();
    check_eq("b2b_end", wb_valid, 1'b0);
    check_eq("b2b_hs_none", 64'(hs_q.size()), 64'd0);

    // Flush while offering in IDLE.
    set_op(1'b0, 1'b0, 3'd0, 3'd1, 5'd3, 32'h0, 32'h77, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_idle_wb", wb_valid, 1'b0);

    // Flush during RSP of a LW.
    mem_delay_min = 4; mem_delay_max = 4;
    set_op(1'b1, 1'b0, 3'b010, 3'b001, 5'd12, 32'h300, 32'h6000, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("flush_rsp_busy", in_ready, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(wb_valid);
      tick();
    end
    check_eq("flush_rsp_wb", 64'(pulses), 64'd0);
    check_eq("flush_rsp_ready", in_ready, 1'b1);
    pop_hs("flush_rsp", h);

    // Flush in REQ while memory is not ready: request withdrawn.
    mem_mode = 2;
    set_op(1'b1, 1'b0, 3'b010, 3'b001, 5'd13, 32'h304, 32'h6100, 32'h0);
    tick();
    in_valid = 1'b0;
    check_eq("flush_req_pre", dmem.dmem_req_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_req_withdrawn", dmem.dmem_req_valid, 1'b0);
    check_eq("flush_req_ready", in_ready, 1'b1);
    check_eq("flush_req_wb", wb_valid, 1'b0);
    mem_mode = 1;
    tick(); tick();
    check_eq("flush_req_hs_none", 64'(hs_q.size()), 64'd0);

    // Flush in REQ with same-cycle handshake on a store: committed, not retired.
    mem_delay_min = 0; mem_delay_max = 0;
    set_op(1'b0, 1'b1, 3'b010, 3'b010, 5'd14, 32'h308, 32'h6200, 32'h1234_5678);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_st_wb", wb_valid, 1'b0);
    check_eq("flush_st_ready", in_ready, 1'b1);
    pop_hs("flush_st", h);
    check_eq("flush_st_we", h.we, 1'b1);

    // Reset while waiting for a load response; the late response must be ignored.
    mem_delay_min = 8; mem_delay_max = 8;
    set_op(1'b1, 1'b0, 3'b010, 3'b101, 5'd15, 32'h400, 32'h7000, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    #1 reset_n = 1'b0;
    #1;
    check_eq("mrst_wb_valid", wb_valid, 1'b0);
    check_eq("mrst_wb_ctrl", wb_ctrl, '0);
    check_eq("mrst_wb_rd", wb_rd, '0);
    check_eq("mrst_wb_pc4", wb_pc4, '0);
    check_eq("mrst_wb_mem", wb_mem_data, '0);
    check_eq("mrst_wb_alu", wb_alu_data, '0);
    check_eq("mrst_wb_mis", wb_misaligned, 1'b0);
    check_eq("mrst_req_valid", dmem.dmem_req_valid, 1'b0);
    check_eq("mrst_in_ready", in_ready, 1'b1);
    #1 reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      pulses += int'(wb_valid);
    end
    check_eq("mrst_stray_ignored", 64'(pulses), 64'd0);
    hs_q.delete();

    // Randomized stream with a randomly stalling memory.
    mem_mode = 0; mem_delay_min = 0; mem_delay_max = 3;
    for (int i = 0; i < 80; i++) begin
      logic [2:0] f3;
      int         kind;
      kind = $urandom_range(0, 2);
      f3   = {1'($urandom), 2'($urandom_range(0, 3))};
      run_op(i, kind, f3, CW'($urandom), RW'($urandom), XLEN'($urandom),
             XLEN'($urandom), XLEN'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0, expected 0x1");
    $fatal(1, "timeout");
  end
endmodule
